// File: rtl/srt4_host_if.sv
// srt4_host_if
//   Host-side front end for the SRT4 divider control unit (CU) and datapath.
//   This block does the following:
//   - Accepts one divide request per valid/ready handshake.
//   - Traps a zero divisor locally, without starting the CU.
//   - Pulses beginSignal for one cycle.
//   - Drives the operand bus (inbus) while the CU asks for operands.
//   - Captures quotient and remainder from outbus.
//   - Holds the response until the host accepts it.
//   - Bounds every run with a watchdog.
//
// Parameters
//   WIDTH    operand / result width
//   TIMEOUT  maximum RUN cycles before the run is aborted
//   TCNT_W   watchdog counter width; 2**TCNT_W must exceed TIMEOUT
//
// Ports
//   clk, rst_b                          clock (rising edge), synchronous active-low reset
//   req_valid/req_ready                 request handshake
//   req_dividend/req_divisor            request operands
//   rsp_valid/rsp_ready                 response handshake
//   rsp_quotient/rsp_remainder          response results
//   rsp_div0/rsp_timeout                response flags
//   busy                                high whenever the FSM is not idle
//   beginSignal/endSignal               start pulse to the CU / completion strobe from the CU
//   ld_dividend/ld_divisor              CU asks for an operand on inbus
//   out_quot/out_rem                    CU presents a result on outbus
//   inbus/outbus                        operand bus to the datapath / result bus from the datapath
module srt4_host_if #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 128,
  parameter int TCNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_dividend,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_quotient,
  output logic [WIDTH-1:0] rsp_remainder,
  output logic             rsp_div0,
  output logic             rsp_timeout,
  output logic             busy,
  output logic             beginSignal,
  input  logic             endSignal,
  input  logic             ld_dividend,
  input  logic             ld_divisor,
  input  logic             out_quot,
  input  logic             out_rem,
  output logic [WIDTH-1:0] inbus,
  input  logic [WIDTH-1:0] outbus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);

  logic [1:0]        state_q, state_d;
  logic [WIDTH-1:0]  dvd_q,   dvd_d;
  logic [WIDTH-1:0]  dvs_q,   dvs_d;
  logic [WIDTH-1:0]  quot_q,  quot_d;
  logic [WIDTH-1:0]  rem_q,   rem_d;
  logic              div0_q,  div0_d;
  logic              tout_q,  tout_d;
  logic [TCNT_W-1:0] tcnt_q,  tcnt_d;

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    div0_d  = div0_q;
    tout_d  = tout_q;
    tcnt_d  = tcnt_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          dvd_d  = req_dividend;
          dvs_d  = req_divisor;
          quot_d = '0;
          rem_d  = '0;
          div0_d = 1'b0;
          tout_d = 1'b0;
          tcnt_d = '0;
          // A zero divisor would keep the CU normalisation loop spinning
          // forever, so answer it here and never start the CU.
          if (req_divisor == '0) begin
            quot_d  = '1;
            rem_d   = req_dividend;
            div0_d  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_START;
          end
        end
      end
      S_START: begin
        state_d = S_RUN;
      end
      S_RUN: begin
        if (out_quot) quot_d = outbus;
        if (out_rem)  rem_d  = outbus;
        tcnt_d = tcnt_q + 1'b1;
        // endSignal is checked first so that a completion on the very
        // cycle the watchdog expires still counts as a good result.
        if (endSignal) begin
          state_d = S_RESP;
        end else if (tcnt_q == TCNT_LAST) begin
          quot_d  = '0;
          rem_d   = '0;
          tout_d  = 1'b1;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      div0_q  <= 1'b0;
      tout_q  <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      div0_q  <= div0_d;
      tout_q  <= tout_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // req_ready is gated by rst_b so that no request is taken while the
  // block is held in reset.
  assign req_ready     = rst_b && (state_q == S_IDLE);
  assign rsp_valid     = (state_q == S_RESP);
  assign busy          = (state_q != S_IDLE);
  assign beginSignal   = (state_q == S_START);
  assign rsp_quotient  = quot_q;
  assign rsp_remainder = rem_q;
  assign rsp_div0      = div0_q;
  assign rsp_timeout   = tout_q;

  // When both load strobes are high, the dividend has priority.
  always_comb begin
    inbus = '0;
    if (state_q == S_RUN) begin
      if (ld_dividend)     inbus = dvd_q;
      else if (ld_divisor) inbus = dvs_q;
    end
  end

endmodule

// File: tb/tb_srt4_host_if.sv
// tb_srt4_host_if
//   Directed bench for srt4_host_if. The control unit is played by the bench
//   itself, which drives the ld_*, out_* and endSignal strobes cycle by cycle.
//   Inputs change and outputs are sampled on the falling clock edge.
module tb_srt4_host_if;

  logic       clk = 1'b0;
  logic       rst_b;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_dividend;
  logic [7:0] req_divisor;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_quotient;
  logic [7:0] rsp_remainder;
  logic       rsp_div0;
  logic       rsp_timeout;
  logic       busy;
  logic       beginSignal;
  logic       endSignal;
  logic       ld_dividend;
  logic       ld_divisor;
  logic       out_quot;
  logic       out_rem;
  logic [7:0] inbus;
  logic [7:0] outbus;

  int n_vec = 0;
  int n_bad = 0;
  int begin_cnt = 0;

  srt4_host_if #(.WIDTH(8), .TIMEOUT(128), .TCNT_W(8)) dut (
    .clk(clk), .rst_b(rst_b),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_div0(rsp_div0), .rsp_timeout(rsp_timeout),
    .busy(busy), .beginSignal(beginSignal), .endSignal(endSignal),
    .ld_dividend(ld_dividend), .ld_divisor(ld_divisor),
    .out_quot(out_quot), .out_rem(out_rem),
    .inbus(inbus), .outbus(outbus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (beginSignal === 1'b1) begin_cnt <= begin_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_req(input logic [7:0] a, input logic [7:0] b);
    req_valid    = 1'b1;
    req_dividend = a;
    req_divisor  = b;
    tick();
    req_valid    = 1'b0;
  endtask

  // Full transaction with a well-behaved CU: quotient, remainder, end.
  task automatic run_normal(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] q, input logic [7:0] r);
    send_req(a, b);
    chk({tag, " begin"}, beginSignal, 1'b1);
    tick();
    out_quot = 1'b1; outbus = q;
    tick();
    out_quot = 1'b0; out_rem = 1'b1; outbus = r;
    tick();
    out_rem = 1'b0; outbus = 8'h00; endSignal = 1'b1;
    tick();
    endSignal = 1'b0;
    chk({tag, " rsp"}, {rsp_valid, rsp_div0, rsp_timeout, rsp_quotient, rsp_remainder},
        {1'b1, 1'b0, 1'b0, q, r});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, " idle"}, {rsp_valid, req_ready, busy}, 3'b010);
  endtask

  initial begin
    int run;
    int bc0;
    rst_b = 1'b0; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
    rsp_ready = 1'b0; endSignal = 1'b0; ld_dividend = 1'b0; ld_divisor = 1'b0;
    out_quot = 1'b0; out_rem = 1'b0; outbus = '0;

    // Reset state
    tick(); tick();
    chk("reset outputs", {req_ready, rsp_valid, busy, beginSignal, rsp_div0, rsp_timeout,
                          rsp_quotient, rsp_remainder, inbus}, '0);
    rst_b = 1'b1;
    #1 chk("ready after reset", req_ready, 1'b1);

    // T1 + T3: 100/7 -> 14 r 2, with operand loads checked on inbus
    send_req(8'd100, 8'd7);
    chk("T1 start", {beginSignal, busy, rsp_valid}, 3'b110);
    ld_dividend = 1'b1;
    #1 chk("T3 inbus in START", inbus, 8'd0);
    tick();
    chk("T1 begin one cycle", beginSignal, 1'b0);
    #1 chk("T3 inbus dividend", inbus, 8'd100);
    tick();
    ld_dividend = 1'b0; ld_divisor = 1'b1;
    #1 chk("T3 inbus divisor", inbus, 8'd7);
    tick();
    ld_divisor = 1'b0;
    #1 chk("T3 inbus idle", inbus, 8'd0);
    ld_dividend = 1'b1; ld_divisor = 1'b1;
    #1 chk("T3 inbus priority", inbus, 8'd100);
    tick();
    ld_dividend = 1'b0; ld_divisor = 1'b0; out_quot = 1'b1; outbus = 8'd14;
    tick();
    out_quot = 1'b0; out_rem = 1'b1; outbus = 8'd2;
    tick();
    out_rem = 1'b0; outbus = 8'd0; endSignal = 1'b1;
    tick();
    endSignal = 1'b0;
    chk("T1 rsp", {rsp_valid, req_ready, rsp_div0, rsp_timeout, rsp_quotient, rsp_remainder},
        {1'b1, 1'b0, 1'b0, 1'b0, 8'd14, 8'd2});

    // T4: host stalls for 10 cycles while a new request (T2 operands) waits
    req_valid = 1'b1; req_dividend = 8'h5A; req_divisor = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("T4 hold", {rsp_valid, req_ready, busy, rsp_div0, rsp_timeout, rsp_quotient, rsp_remainder},
          {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd14, 8'd2});
    end
    bc0 = begin_cnt;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("T4 after handshake", {rsp_valid, req_ready, rsp_quotient}, {1'b0, 1'b1, 8'd14});

    // T2: divisor 0 is answered locally one cycle after acceptance
    tick();
    req_valid = 1'b0;
    chk("T2 div0 rsp", {rsp_valid, rsp_div0, rsp_timeout, rsp_quotient, rsp_remainder},
        {1'b1, 1'b1, 1'b0, 8'hFF, 8'h5A});
    tick();
    chk("T2 no begin", begin_cnt, bc0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("T2 idle", {rsp_valid, busy, rsp_div0}, 3'b001);

    // T5: CU never ends; a stray out_quot early on must not survive the abort
    send_req(8'd50, 8'd5);
    run = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (rsp_valid === 1'b1) break;
      run++;
      if (i == 0) begin out_quot = 1'b1; outbus = 8'h33; end
      else begin out_quot = 1'b0; outbus = 8'h00; end
    end
    chk("T5 run cycles", run, 128);
    chk("T5 rsp", {rsp_valid, rsp_div0, rsp_timeout, rsp_quotient, rsp_remainder},
        {1'b1, 1'b0, 1'b1, 8'd0, 8'd0});
    endSignal = 1'b1;
    tick();
    endSignal = 1'b0;
    chk("T5 late end in RESP", {rsp_valid, rsp_timeout, rsp_quotient}, {1'b1, 1'b1, 8'd0});
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    endSignal = 1'b1;
    tick();
    endSignal = 1'b0;
    chk("T5 late end in IDLE", {busy, rsp_valid, req_ready, rsp_timeout}, 4'b0011);

    // T6: reset mid-RUN aborts silently, the next request completes normally
    send_req(8'd100, 8'd7);
    tick();
    out_quot = 1'b1; outbus = 8'd14;
    tick();
    out_quot = 1'b0; outbus = 8'd0;
    rst_b = 1'b0;
    tick();
    chk("T6 reset mid-run", {busy, rsp_valid, req_ready, beginSignal, rsp_div0, rsp_timeout,
                             rsp_quotient, rsp_remainder, inbus}, '0);
    rst_b = 1'b1;
    #1 chk("T6 ready", req_ready, 1'b1);
    run_normal("T6 rerun", 8'd100, 8'd7, 8'd14, 8'd2);
    run_normal("T6 second", 8'd200, 8'd9, 8'd22, 8'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
